// File: rtl/frame_packer_if.sv
// Command, payload and framed-output bundle between a frame source and
// frame_packer.
interface frame_packer_if;
   // Handshakes: a word or command moves on a rising clk_in edge where valid
   // and ready are both high; valid may rise without waiting for ready, and
   // the source holds its data stable until the transfer completes.
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_ch;
   logic [2:0]  cmd_len_m1;
   logic        pld_valid;
   logic        pld_ready;
   logic [15:0] pld_data;
   logic [15:0] data_out;
   logic        data_out_vld;

   modport master (
      output cmd_valid, cmd_ch, cmd_len_m1, pld_valid, pld_data,
      input  cmd_ready, pld_ready, data_out, data_out_vld
   );

   modport slave (
      input  cmd_valid, cmd_ch, cmd_len_m1, pld_valid, pld_data,
      output cmd_ready, pld_ready, data_out, data_out_vld
   );
endinterface

// File: rtl/frame_packer.sv
// Buffers a 1-8 word payload, computes CRC-16-CCITT over it and emits
// header, channel, payload, CRC and trailer as one contiguous word stream.
module frame_packer #(
   parameter logic [31:0] HEADER    = 32'hE0E0E0E0,
   parameter logic [31:0] TRAILER   = 32'h0E0E0E0E,
   parameter logic [15:0] IDLE_WORD = 16'h0000,
   parameter int          MAX_WORDS = 8
) (
   input  logic          clk_in,
   input  logic          rst_n,
   frame_packer_if.slave bus,
   output logic          busy,
   output logic          err_ch,
   output logic [15:0]   frame_cnt,
   output logic [3:0]    state_dbg
);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_HDR_H, S_HDR_L, S_CH, S_PLD, S_CRC, S_TRL_H, S_TRL_L
   } state_t;

   state_t      state_q, state_nxt;
   logic [2:0]  cnt_q, cnt_nxt;
   logic [2:0]  len_q;
   logic [7:0]  ch_q;
   logic [15:0] crc_q;
   logic [15:0] pld_buf [MAX_WORDS];
   logic [15:0] dout_nxt;
   logic        vld_nxt;
   logic        ch_onehot;
   logic        cmd_acc;
   logic        pld_acc;

   function automatic logic [15:0] crc_update(input logic [15:0] c, input logic [15:0] d);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 15; i >= 0; i--) begin
         fb = d[i] ^ r[15];
         r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return r;
   endfunction

   assign ch_onehot = (bus.cmd_ch != 8'h00) && ((bus.cmd_ch & (bus.cmd_ch - 8'd1)) == 8'h00);
   assign cmd_acc   = (state_q == S_IDLE) && bus.cmd_valid;
   assign pld_acc   = (state_q == S_LOAD) && bus.pld_valid;
   assign state_dbg = state_q;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   // cnt is the write index while loading and the read index while sending payload.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      unique case (state_q)
         S_IDLE: if (cmd_acc && ch_onehot) begin
            state_nxt = S_LOAD;
            cnt_nxt   = 3'd0;
         end
         S_LOAD: if (pld_acc) begin
            if (cnt_q == len_q) begin
               state_nxt = S_HDR_H;
               cnt_nxt   = 3'd0;
            end else begin
               cnt_nxt = cnt_q + 3'd1;
            end
         end
         S_HDR_H: state_nxt = S_HDR_L;
         S_HDR_L: state_nxt = S_CH;
         S_CH:    state_nxt = S_PLD;
         S_PLD: begin
            if (cnt_q == len_q) begin
               state_nxt = S_CRC;
               cnt_nxt   = 3'd0;
            end else begin
               cnt_nxt = cnt_q + 3'd1;
            end
         end
         S_CRC:   state_nxt = S_TRL_H;
         S_TRL_H: state_nxt = S_TRL_L;
         S_TRL_L: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // The output word is chosen from the next state so it is registered and
   // appears exactly in the cycle its state is entered.
   always_comb begin
      bus.cmd_ready = (state_q == S_IDLE);
      bus.pld_ready = (state_q == S_LOAD);
      busy          = (state_q != S_IDLE);
      dout_nxt      = IDLE_WORD;
      vld_nxt       = 1'b1;
      unique case (state_nxt)
         S_HDR_H: dout_nxt = HEADER[31:16];
         S_HDR_L: dout_nxt = HEADER[15:0];
         S_CH:    dout_nxt = {8'h00, ch_q};
         S_PLD:   dout_nxt = pld_buf[cnt_nxt];
         S_CRC:   dout_nxt = crc_q;
         S_TRL_H: dout_nxt = TRAILER[31:16];
         S_TRL_L: dout_nxt = TRAILER[15:0];
         default: vld_nxt  = 1'b0;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         bus.data_out     <= IDLE_WORD;
         bus.data_out_vld <= 1'b0;
         err_ch           <= 1'b0;
         frame_cnt        <= 16'h0000;
         crc_q            <= 16'h0000;
         ch_q             <= 8'h00;
         len_q            <= 3'd0;
      end else begin
         bus.data_out     <= dout_nxt;
         bus.data_out_vld <= vld_nxt;
         err_ch           <= cmd_acc && !ch_onehot;
         if (cmd_acc && ch_onehot) begin
            ch_q  <= bus.cmd_ch;
            len_q <= bus.cmd_len_m1;
            crc_q <= 16'h0000;
         end else if (pld_acc) begin
            crc_q <= crc_update(crc_q, bus.pld_data);
         end
         if (state_q == S_TRL_L) frame_cnt <= frame_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (pld_acc) pld_buf[cnt_q] <= bus.pld_data;
   end

endmodule

// File: tb/tb_frame_packer.sv
// Self-checking bench for frame_packer: table vectors, randomized frames
// against a long-division CRC model, and reset/error/wrap corner sequences.
module tb_frame_packer;

   logic        clk_in = 1'b0;
   logic        rst_n;
   logic        busy;
   logic        err_ch;
   logic [15:0] frame_cnt;
   logic [3:0]  state_dbg;

   frame_packer_if bus ();

   frame_packer dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .bus       (bus),
      .busy      (busy),
      .err_ch    (err_ch),
      .frame_cnt (frame_cnt),
      .state_dbg (state_dbg)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0]  ch;
      logic [2:0]  len_m1;
      logic [15:0] words [8];
      bit          gap;
      bit          crc_known;
      logic [15:0] exp_crc;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_cnt  = 16'h0000;
   logic [15:0] cur_words [8];
   logic [15:0] exp_q [$];
   vec_t        vecs [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // CRC as remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
   function automatic logic [15:0] model_crc(input int n);
      bit          bits [$];
      logic [16:0] poly = 17'h11021;
      logic [15:0] r;
      for (int w = 0; w < n; w++)
         for (int b = 15; b >= 0; b--) bits.push_back(cur_words[w][b]);
      for (int k = 0; k < 16; k++) bits.push_back(1'b0);
      for (int i = 0; i < bits.size() - 16; i++)
         if (bits[i])
            for (int j = 0; j <= 16; j++) bits[i + j] = bits[i + j] ^ poly[16 - j];
      for (int k = 0; k < 16; k++) r[15 - k] = bits[bits.size() - 16 + k];
      return r;
   endfunction

   task automatic send_cmd(input logic [7:0] ch, input logic [2:0] lm1);
      int budget = 20;
      bus.cmd_valid  = 1'b1;
      bus.cmd_ch     = ch;
      bus.cmd_len_m1 = lm1;
      while (!bus.cmd_ready && budget > 0) begin
         tick();
         budget--;
      end
      if (budget == 0) check("cmd_ready_timeout", 32'd0, 32'd1);
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   // Leaves the bench in the cycle just after the final payload handshake.
   task automatic send_payload(input logic [2:0] lm1, input bit gap, input bit rnd_gap);
      for (int w = 0; w <= int'(lm1); w++) begin
         int budget = 20;
         int idle   = gap ? 1 : (rnd_gap ? $urandom_range(0, 2) : 0);
         for (int g = 0; g < idle; g++) begin
            bus.pld_valid = 1'b0;
            bus.pld_data  = 16'($urandom);
            tick();
            check("vld_during_load", 32'(bus.data_out_vld), 32'd0);
         end
         bus.pld_valid = 1'b1;
         bus.pld_data  = cur_words[w];
         while (!bus.pld_ready && budget > 0) begin
            tick();
            budget--;
         end
         if (budget == 0) check("pld_ready_timeout", 32'd0, 32'd1);
         if (w != 0) check("vld_during_load", 32'(bus.data_out_vld), 32'd0);
         tick();
      end
      bus.pld_valid = 1'b0;
   endtask

   task automatic check_frame(input logic [7:0] ch, input logic [2:0] lm1, input logic [15:0] crc);
      int n = int'(lm1) + 1;
      exp_q.delete();
      exp_q.push_back(16'hE0E0);
      exp_q.push_back(16'hE0E0);
      exp_q.push_back({8'h00, ch});
      for (int w = 0; w < n; w++) exp_q.push_back(cur_words[w]);
      exp_q.push_back(crc);
      exp_q.push_back(16'h0E0E);
      exp_q.push_back(16'h0E0E);
      for (int i = 0; i < 6 + n; i++) begin
         logic [15:0] e = exp_q.pop_front();
         check($sformatf("frame_vld[%0d]", i), 32'(bus.data_out_vld), 32'd1);
         check($sformatf("frame_word[%0d]", i), 32'(bus.data_out), 32'(e));
         bus.pld_valid = $urandom_range(0, 1) == 1;
         bus.pld_data  = 16'($urandom);
         tick();
      end
      bus.pld_valid = 1'b0;
      exp_cnt = exp_cnt + 16'd1;
      check("end_data", 32'(bus.data_out), 32'h0000);
      check("end_vld", 32'(bus.data_out_vld), 32'd0);
      check("end_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
      check("end_busy", 32'(busy), 32'd0);
   endtask

   task automatic run_frame(input logic [7:0] ch, input logic [2:0] lm1, input bit gap,
                            input bit rnd_gap, input logic [15:0] crc);
      send_cmd(ch, lm1);
      send_payload(lm1, gap, rnd_gap);
      check_frame(ch, lm1, crc);
      if ($urandom_range(0, 1) == 1) tick();
   endtask

   initial begin
      bus.cmd_valid  = 1'b0;
      bus.cmd_ch     = 8'h00;
      bus.cmd_len_m1 = 3'd0;
      bus.pld_valid  = 1'b0;
      bus.pld_data   = 16'h0000;

      vecs[0] = '{ch: 8'h01, len_m1: 3'd0, words: '{16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                  gap: 1'b0, crc_known: 1'b1, exp_crc: 16'h1B98};
      vecs[1] = '{ch: 8'h80, len_m1: 3'd1, words: '{16'h0000, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                  gap: 1'b0, crc_known: 1'b1, exp_crc: 16'h1021};
      vecs[2] = '{ch: 8'h10, len_m1: 3'd7, words: '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                  gap: 1'b1, crc_known: 1'b1, exp_crc: 16'h0000};
      vecs[3] = '{ch: 8'h04, len_m1: 3'd3, words: '{16'hE0E0, 16'hE0E0, 16'h0E0E, 16'h0E0E, 16'h0, 16'h0, 16'h0, 16'h0},
                  gap: 1'b0, crc_known: 1'b0, exp_crc: 16'h0000};

      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_data", 32'(bus.data_out), 32'h0000);
      check("rst_vld", 32'(bus.data_out_vld), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err_ch", 32'(err_ch), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'h0000);
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst_pld_ready", 32'(bus.pld_ready), 32'd0);
      @(negedge clk_in);
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < 4; v++) begin
         logic [15:0] crc;
         for (int w = 0; w < 8; w++) cur_words[w] = vecs[v].words[w];
         crc = vecs[v].crc_known ? vecs[v].exp_crc : model_crc(int'(vecs[v].len_m1) + 1);
         run_frame(vecs[v].ch, vecs[v].len_m1, vecs[v].gap, 1'b0, crc);
      end

      // Rejected commands: non-one-hot channel values.
      for (int k = 0; k < 2; k++) begin
         logic [7:0] bad = (k == 0) ? 8'h03 : 8'h00;
         send_cmd(bad, 3'd2);
         check("err_ch_pulse", 32'(err_ch), 32'd1);
         check("err_vld", 32'(bus.data_out_vld), 32'd0);
         check("err_busy", 32'(busy), 32'd0);
         tick();
         check("err_ch_clear", 32'(err_ch), 32'd0);
         check("err_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
      end
      cur_words[0] = 16'h1234;
      cur_words[1] = 16'hABCD;
      run_frame(8'h02, 3'd1, 1'b0, 1'b0, model_crc(2));

      for (int r = 0; r < 40; r++) begin
         logic [7:0] ch  = 8'h01 << $urandom_range(0, 7);
         logic [2:0] lm1 = 3'($urandom_range(0, 7));
         for (int w = 0; w < 8; w++) begin
            case ($urandom_range(0, 5))
               0:       cur_words[w] = 16'hE0E0;
               1:       cur_words[w] = 16'h0E0E;
               default: cur_words[w] = 16'($urandom);
            endcase
         end
         run_frame(ch, lm1, 1'b0, 1'b1, model_crc(int'(lm1) + 1));
      end

      // Reset in the middle of the payload section of an 8-word frame.
      for (int w = 0; w < 8; w++) cur_words[w] = 16'($urandom);
      send_cmd(8'h08, 3'd7);
      send_payload(3'd7, 1'b0, 1'b0);
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      check("midrst_data", 32'(bus.data_out), 32'h0000);
      check("midrst_vld", 32'(bus.data_out_vld), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      tick();
      @(negedge clk_in);
      rst_n = 1'b1;
      tick();
      exp_cnt = 16'h0000;
      check("postrst_busy", 32'(busy), 32'd0);
      check("postrst_vld", 32'(bus.data_out_vld), 32'd0);
      check("postrst_frame_cnt", 32'(frame_cnt), 32'h0000);
      for (int w = 0; w < 8; w++) cur_words[w] = 16'($urandom);
      run_frame(8'h40, 3'd7, 1'b0, 1'b0, model_crc(8));

      // Counter wrap: preload to FFFF while idle, then send one more frame.
      force dut.frame_cnt = 16'hFFFF;
      tick();
      release dut.frame_cnt;
      tick();
      exp_cnt = 16'hFFFF;
      check("preload_frame_cnt", 32'(frame_cnt), 32'h0000FFFF);
      cur_words[0] = 16'h5A5A;
      run_frame(8'h20, 3'd0, 1'b0, 1'b0, model_crc(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
